// File: rtl/clk_tick_pkg.sv
// Shared types and helpers for the multi-channel clock-enable generator.
package clk_tick_pkg;

    localparam int DIV_DISABLE = 0;
    localparam int STATE_CNT_W = 32;

    function automatic int SEL_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Per-channel state layout at the default counter width.
    typedef struct packed {
        logic [STATE_CNT_W-1:0] cnt;
        logic [STATE_CNT_W-1:0] div;
        logic [STATE_CNT_W-1:0] shadow;
        logic                   pending;
        logic                   sq;
    } chan_state_t;

endpackage

// File: rtl/clk_tick_gen_if.sv
// Divisor-programming handshake between a CPU-side master and the tick generator.
interface clk_tick_gen_if
    import clk_tick_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 32
);
    localparam int SEL_BITS = SEL_W(CHANNELS);

    logic                cfg_valid;
    logic [SEL_BITS-1:0] cfg_sel;
    logic [CNT_W-1:0]    cfg_div;
    logic                cfg_ready;

    modport master (output cfg_valid, cfg_sel, cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, cfg_sel, cfg_div, output cfg_ready);

endinterface

// File: rtl/clk_tick_chan.sv
// One divider channel: counter, shadowed divisor with pending flag, tick and square-wave registers.
module clk_tick_chan
    import clk_tick_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             sq,
    output logic             pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] shadow;
    logic             disabled;
    logic             wrap;

    assign disabled = (div == CNT_W'(DIV_DISABLE));
    assign wrap     = !disabled && adv && (cnt == div - CNT_W'(1));

    // A new divisor only lands on a wrap (or at once when disabled), so no runt period is ever emitted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            div     <= CNT_W'(DEFAULT_DIV);
            shadow  <= '0;
            pending <= 1'b0;
            tick    <= 1'b0;
            sq      <= 1'b0;
        end else begin
            tick <= wrap;
            if (wrap) begin
                cnt <= '0;
                sq  <= ~sq;
            end else if (!disabled && adv) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (pending && (disabled || wrap)) begin
                div     <= shadow;
                pending <= 1'b0;
            end else if (wr) begin
                shadow  <= wr_div;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_tick_gen.sv
// Free-running prescaler plus CHANNELS runtime-programmable clock-enable dividers with freeze/step.
module clk_tick_gen #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 32,
    parameter int CLKDIV_W    = 32,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                step,
    clk_tick_gen_if.slave       cfg,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] sq,
    output logic [CLKDIV_W-1:0] clkdiv
);

    logic                adv;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] wr;

    assign adv = en | (step & ~en);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clkdiv <= '0;
        end else begin
            clkdiv <= clkdiv + CLKDIV_W'(1);
        end
    end

    // Out-of-range selects keep ready high and write nothing, so the master never stalls on them.
    always_comb begin
        cfg.cfg_ready = 1'b1;
        wr            = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(cfg.cfg_sel) == i) begin
                cfg.cfg_ready = ~pending[i];
                wr[i]         = cfg.cfg_valid && !pending[i];
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        clk_tick_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .adv     (adv),
            .wr      (wr[i]),
            .wr_div  (cfg.cfg_div),
            .tick    (tick[i]),
            .sq      (sq[i]),
            .pending (pending[i])
        );
    end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Directed plus randomized bench for clk_tick_gen against a countdown-based reference model.
module tb_clk_tick_gen;

    localparam int CH  = 4;
    localparam int CW  = 32;
    localparam int KW  = 4;
    localparam int DEF = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          step;
    logic [CH-1:0] tick;
    logic [CH-1:0] sq;
    logic [KW-1:0] clkdiv;

    logic          one = 1'b1;
    logic          zero = 1'b0;
    logic [2:0]    tick3;
    logic [2:0]    sq3;
    logic [7:0]    clkdiv3;

    clk_tick_gen_if #(.CHANNELS(CH), .CNT_W(CW)) cfg_bus ();
    clk_tick_gen_if #(.CHANNELS(3), .CNT_W(CW))  cfg3 ();

    clk_tick_gen #(.CHANNELS(CH), .CNT_W(CW), .CLKDIV_W(KW), .DEFAULT_DIV(DEF)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .step   (step),
        .cfg    (cfg_bus),
        .tick   (tick),
        .sq     (sq),
        .clkdiv (clkdiv)
    );

    clk_tick_gen #(.CHANNELS(3), .CNT_W(CW), .CLKDIV_W(8), .DEFAULT_DIV(DEF)) dut3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (one),
        .step   (zero),
        .cfg    (cfg3),
        .tick   (tick3),
        .sq     (sq3),
        .clkdiv (clkdiv3)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: each channel counts down the advances left until its next tick.
    logic [31:0] m_div [CH];
    logic [31:0] m_shadow [CH];
    int          m_left [CH];
    bit          m_pend [CH];
    bit          m_sq [CH];
    bit          m_tick [CH];
    int          m_clk = 0;
    bit          m_valid = 0;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_ready(input int sel);
        if (sel >= CH) return 1'b1;
        return !m_pend[sel];
    endfunction

    function automatic void model_edge(input logic r, input logic adv, input logic acc,
                                       input int sel, input logic [31:0] d);
        if (!r) begin
            m_clk   = 0;
            m_valid = 1;
            for (int i = 0; i < CH; i++) begin
                m_div[i] = DEF; m_shadow[i] = 0; m_pend[i] = 0;
                m_left[i] = DEF; m_sq[i] = 0; m_tick[i] = 0;
            end
            return;
        end
        m_clk = (m_clk + 1) % (1 << KW);
        for (int i = 0; i < CH; i++) begin
            m_tick[i] = 0;
            if (m_div[i] == 0) begin
                if (m_pend[i]) begin
                    m_div[i] = m_shadow[i]; m_left[i] = int'(m_shadow[i]); m_pend[i] = 0;
                end
            end else if (adv) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_tick[i] = 1;
                    m_sq[i] = !m_sq[i];
                    if (m_pend[i]) begin
                        m_div[i] = m_shadow[i]; m_pend[i] = 0;
                    end
                    m_left[i] = int'(m_div[i]);
                end
            end
        end
        if (acc && sel < CH) begin
            m_shadow[sel] = d;
            m_pend[sel] = 1;
        end
    endfunction

    task automatic apply_stimulus(input logic r, input logic e, input logic s, input logic v,
                                  input int sel, input logic [31:0] d);
        logic          acc;
        logic [CH-1:0] exp_tick;
        logic [CH-1:0] exp_sq;
        rst_n = r; en = e; step = s;
        cfg_bus.cfg_valid = v;
        cfg_bus.cfg_sel   = 2'(sel);
        cfg_bus.cfg_div   = d;
        #1;
        if (m_valid) check_output("cfg_ready", 32'(cfg_bus.cfg_ready), 32'(model_ready(sel)));
        acc = v && model_ready(sel);
        model_edge(r, e || s, acc, sel, d);
        @(posedge clk);
        #1;
        for (int i = 0; i < CH; i++) begin
            exp_tick[i] = m_tick[i];
            exp_sq[i]   = m_sq[i];
        end
        check_output("tick", 32'(tick), 32'(exp_tick));
        check_output("sq", 32'(sq), 32'(exp_sq));
        check_output("clkdiv", 32'(clkdiv), 32'(m_clk));
    endtask

    task automatic run_idle(input int n, input logic e);
        for (int i = 0; i < n; i++) apply_stimulus(1'b1, e, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        cfg3.cfg_valid = 1'b0;
        cfg3.cfg_sel   = '0;
        cfg3.cfg_div   = '0;

        // Reset defaults, then free running with DEFAULT_DIV on every channel.
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        check_output("reset_tick", 32'(tick), 32'd0);
        check_output("reset_clkdiv", 32'(clkdiv), 32'd0);
        run_idle(12, 1'b1);

        // Mid-period divisor change on ch1, then a second write held until pending clears.
        run_idle(2, 1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1, 5);
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1, 3);
        run_idle(16, 1'b1);

        // Freeze and single-step on ch0 with div=3.
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 0, 3);
        run_idle(7, 1'b1);
        run_idle(20, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        end
        for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);

        // Disable ch2, then re-enable it with div=1.
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 2, 0);
        run_idle(8, 1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 2, 1);
        run_idle(6, 1'b1);

        // Pending update on a frozen channel is discarded by reset.
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 3, 9);
        run_idle(3, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 3, 0);
        run_idle(6, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            apply_stimulus(logic'($urandom_range(0, 99) != 0), logic'($urandom_range(0, 3) != 0),
                           logic'($urandom_range(0, 1)), logic'($urandom_range(0, 2) == 0),
                           int'($urandom_range(0, 3)), 32'($urandom_range(0, 6)));
        end

        // Out-of-range select on a 3-channel instance is accepted and changes nothing.
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        cfg3.cfg_valid = 1'b1;
        cfg3.cfg_sel   = 2'd3;
        cfg3.cfg_div   = 32'd7;
        for (int k = 1; k <= 8; k++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
            check_output("oor_ready", 32'(cfg3.cfg_ready), 32'd1);
            check_output("oor_tick", 32'(tick3), (k % 2 == 0) ? 32'h7 : 32'h0);
            check_output("oor_sq", 32'(sq3), ((k / 2) % 2 == 1) ? 32'h7 : 32'h0);
        end
        cfg3.cfg_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
